// File: rtl/round_key_expander_pkg.sv
// Shared types, AES S-box table and GF(2^8) helpers for the key expander.
package round_key_expander_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} rke_state_t;

   // Forward AES S-box, indexed by input byte (entry 0 is the leftmost byte).
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/round_key_expander_sub_word.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module sub_word
   import round_key_expander_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);

   // One S-box lookup per byte lane.
   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign sub[8*b +: 8] = sbox(word[8*b +: 8]);
   end

endmodule

// File: rtl/round_key_expander.sv
// AES key schedule: writes one word per cycle into a local word store,
// emits each round key as it completes and serves random-access reads.
module round_key_expander
   import round_key_expander_pkg::*;
#(
   parameter int KEY_WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [32*KEY_WORDS-1:0] key_in,
   output logic                   busy,
   output logic                   done,
   output logic                   rk_valid,
   output logic [3:0]             rk_index,
   output logic [127:0]           rk_data,
   input  logic [3:0]             rd_round,
   output logic [127:0]           rd_data,
   output logic                   keys_ready
);

   localparam int NUM_ROUNDS  = KEY_WORDS + 6;
   localparam int TOTAL_WORDS = 4 * (NUM_ROUNDS + 1);

   rke_state_t state, state_nxt;
   logic [5:0]  idx;                        // word index i being written
   logic [2:0]  kidx;                       // i mod KEY_WORDS, kept incrementally
   logic [7:0]  rcon;
   logic [32*KEY_WORDS-1:0] key_q;          // latched key, shifted out MS word first
   logic [KEY_WORDS-1:0][31:0] win;         // last KEY_WORDS words, win[0] = w[i-1]
   logic [31:0] mem [TOTAL_WORDS];
   logic [31:0] w_prev, w_old, sw_in, sw_out, t_word, new_word;
   logic [5:0]  rd_base;
   logic        wr_en;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and control outputs; start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      wr_en     = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = LOAD;
         LOAD: begin
            busy  = 1'b1;
            wr_en = 1'b1;
            if (kidx == 3'(KEY_WORDS - 1)) state_nxt = EXPAND;
         end
         EXPAND: begin
            busy  = 1'b1;
            wr_en = 1'b1;
            if (idx == 6'(TOTAL_WORDS - 1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   sub_word u_sub_word (.word(sw_in), .sub(sw_out));

   // Word generator: the single SubWord serves both the rotated and the
   // AES-256 mid-key substitution, which never occur on the same word.
   always_comb begin
      w_prev = win[0];
      w_old  = win[KEY_WORDS-1];
      sw_in  = (kidx == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      if (kidx == 3'd0)                        t_word = sw_out ^ {rcon, 24'h0};
      else if (KEY_WORDS == 8 && kidx == 3'd4) t_word = sw_out;
      else                                     t_word = w_prev;
      new_word = (state == LOAD) ? key_q[32*KEY_WORDS-1 -: 32] : (w_old ^ t_word);
   end

   // Datapath: counters, key shift, word window and round-key emission.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         kidx       <= '0;
         rcon       <= 8'h01;
         key_q      <= '0;
         win        <= '0;
         rk_valid   <= 1'b0;
         rk_index   <= '0;
         rk_data    <= '0;
         keys_ready <= 1'b0;
      end else begin
         rk_valid <= 1'b0;
         if (state == IDLE && start) begin
            key_q      <= key_in;
            keys_ready <= 1'b0;
            idx        <= '0;
            kidx       <= '0;
            rcon       <= 8'h01;
         end
         if (wr_en) begin
            idx  <= idx + 6'd1;
            kidx <= (kidx == 3'(KEY_WORDS - 1)) ? 3'd0 : kidx + 3'd1;
            win  <= {win[KEY_WORDS-2:0], new_word};
            if (state == LOAD) key_q <= key_q << 32;
            if (state == EXPAND && kidx == 3'd0) rcon <= xtime(rcon);
            if (idx[1:0] == 2'd3) begin
               rk_valid <= 1'b1;
               rk_index <= idx[5:2];
               rk_data  <= {win[2], win[1], win[0], new_word};
            end
            if (idx == 6'(TOTAL_WORDS - 1)) keys_ready <= 1'b1;
         end
      end
   end

   // Word store write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= new_word;
   end

   assign rd_base = (rd_round > 4'(NUM_ROUNDS)) ? 6'd0 : {rd_round, 2'b00};

   // Registered random-access round-key read; out-of-range rounds read 0.
   always_ff @(posedge clk) begin
      if (rst)                              rd_data <= '0;
      else if (rd_round > 4'(NUM_ROUNDS))   rd_data <= '0;
      else rd_data <= {mem[rd_base], mem[rd_base + 6'd1],
                       mem[rd_base + 6'd2], mem[rd_base + 6'd3]};
   end

endmodule

// File: tb/tb_round_key_expander.sv
// Scoreboard bench: an independent key-schedule model (S-box derived from the
// GF(2^8) inverse plus affine map) predicts every round key per expansion.
module tb_round_key_expander;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [3:0]    rd_round;
   logic [2:0]    start, busy, done, rk_valid, keys_ready;
   logic [3:0]    rk_index [3];
   logic [127:0]  rk_data [3];
   logic [127:0]  rd_data [3];
   logic [255:0]  key_in [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int KW = 4 + 2*g;
      round_key_expander #(.KEY_WORDS(KW)) dut (
         .clk(clk), .rst(rst), .start(start[g]), .key_in(key_in[g][32*KW-1:0]),
         .busy(busy[g]), .done(done[g]), .rk_valid(rk_valid[g]),
         .rk_index(rk_index[g]), .rk_data(rk_data[g]), .rd_round(rd_round),
         .rd_data(rd_data[g]), .keys_ready(keys_ready[g]));
   end

   typedef struct packed {
      logic [1:0]   id;
      logic [3:0]   idx;
      logic [127:0] data;
   } sb_t;

   sb_t          sb_q[$];
   int           total = 0, bad = 0, cyc = 0, rk_cnt = 0, done_cnt = 0;
   logic [127:0] last_rk;
   logic [7:0]   tsb [256];
   logic [31:0]  mw [60];

   localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         tsb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {tsb[v[31:24]], tsb[v[23:16]], tsb[v[15:8]], tsb[v[7:0]]};
   endfunction

   task automatic model(input logic [255:0] key, input int kw);
      logic [7:0]  rc = 8'h01;
      logic [31:0] t;
      for (int i = 0; i < kw; i++) mw[i] = key[32*(kw-1-i) +: 32];
      for (int i = kw; i < 4*(kw+7); i++) begin
         t = mw[i-1];
         if (i % kw == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (kw == 8 && i % 8 == 4) begin
            t = subw(t);
         end
         mw[i] = mw[i-kw] ^ t;
      end
   endtask

   function automatic logic [127:0] mround(input int r);
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer: every rk_valid pulse pops one prediction.
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rk_valid[g]) begin
            rk_cnt++;
            last_rk = rk_data[g];
            if (sb_q.size() == 0) check("rk_unexpected", 1, 0);
            else begin
               sb_t e;
               e = sb_q.pop_front();
               check("rk_dut", 128'(g), 128'(e.id));
               check("rk_index", rk_index[g], e.idx);
               check("rk_data", rk_data[g], e.data);
            end
         end
         if (done[g]) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int g, input logic [255:0] key);
      model(key, 4 + 2*g);
      for (int r = 0; r <= 10 + 2*g; r++) sb_q.push_back('{2'(g), 4'(r), mround(r)});
   endtask

   task automatic run(input int g, input logic [255:0] key, input logic [127:0] last_exp,
                      input int second_at, input bit start_in_done);
      int nr = 10 + 2*g, tw = 4*(nr + 1), rk0, d0, st, n;
      push_exp(g, key);
      rk0 = rk_cnt; d0 = done_cnt;
      key_in[g] = key; start[g] = 1'b1; st = cyc;
      tick();
      start[g] = 1'b0;
      check("busy_after_start", busy[g], 1);
      if (second_at > 0) begin
         repeat (second_at - 1) tick();
         key_in[g] = ~key; start[g] = 1'b1;
         tick();
         start[g] = 1'b0; key_in[g] = key;
      end
      n = 0;
      while (!done[g] && n < 200) begin tick(); n++; end
      check("done_seen", done[g], 1);
      check("latency", 128'(cyc - st), 128'(tw + 1));
      check("busy_in_done", busy[g], 0);
      if (start_in_done) start[g] = 1'b1;
      tick();
      start[g] = 1'b0;
      check("rk_count", 128'(rk_cnt - rk0), 128'(nr + 1));
      check("done_count", 128'(done_cnt - d0), 1);
      check("sb_empty", 128'(sb_q.size()), 0);
      check("last_round_vector", last_rk, last_exp);
      check("keys_ready", keys_ready[g], 1);
      if (start_in_done) begin
         tick();
         check("start_in_done_ignored", busy[g], 0);
      end
      for (int r = 0; r < 16; r++) begin
         rd_round = 4'(r);
         tick();
         check("rd_sweep", rd_data[g], (r <= nr) ? mround(r) : 128'h0);
      end
   endtask

   task automatic check_reset_outs(input int g);
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
      check("rst_rk_valid", rk_valid[g], 0);
      check("rst_rk_index", rk_index[g], 0);
      check("rst_rk_data", rk_data[g], 0);
      check("rst_rd_data", rd_data[g], 0);
      check("rst_keys_ready", keys_ready[g], 0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = '0; rd_round = '0;
      for (int g = 0; g < 3; g++) key_in[g] = '0;
      build_sbox();
      tick(); tick();
      rst = 1'b0;
      for (int g = 0; g < 3; g++) check_reset_outs(g);

      run(0, K128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 1'b0);
      run(0, K128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 10, 1'b1);

      // Abort 20 cycles into an expansion, then restart.
      push_exp(0, K128);
      key_in[0] = K128; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outs(0);
      sb_q.delete();
      d0 = done_cnt;
      repeat (70) tick();
      check("abort_no_done", 128'(done_cnt - d0), 0);
      check("abort_idle", busy[0], 0);
      run(0, K128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 1'b0);

      // Reset wins over a simultaneous start.
      rst = 1'b1; start[0] = 1'b1;
      tick();
      rst = 1'b0; start[0] = 1'b0;
      check("rst_start_busy", busy[0], 0);
      tick();
      check("rst_start_still_idle", busy[0], 0);

      run(1, K192, 128'he98ba06f448c773c8ecc720401002202, 0, 1'b0);
      run(2, K256, 128'hfe4890d1e6188d0b046df344706c631e, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/round_key_expander.md
ROUND_KEY_EXPANDER -- requirements
Module: round_key_expander

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 4, meaning key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
REQ-002 SHALL derive localparam NUM_ROUNDS = KEY_WORDS+6 and TOTAL_WORDS = 4*(NUM_ROUNDS+1), giving 44, 52 or 60.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request expansion of key_in.
REQ-006 SHALL have port key_in, input, 32*KEY_WORDS bits: cipher key, FIPS-197 byte order, w[0] = MS word.
REQ-007 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the last word is written.
REQ-009 SHALL have port rk_valid, output, 1 bit: one-cycle pulse when a round key is complete.
REQ-010 SHALL have port rk_index, output, 4 bits: round number of rk_data.
REQ-011 SHALL have port rk_data, output, 128 bits: round key, [127:96] = w[4r].
REQ-012 SHALL have port rd_round, input, 4 bits: random-access round select.
REQ-013 SHALL have port rd_data, output, 128 bits: round key rd_round, registered, 1-cycle latency.
REQ-014 SHALL have port keys_ready, output, 1 bit: all TOTAL_WORDS words are valid in storage.

Function
REQ-015 SHALL implement states IDLE, LOAD, EXPAND, DONE.
REQ-016 IDLE: start=1 latches key_in, clears keys_ready, sets word index i=0 and rcon=0x01, and moves to LOAD.
REQ-017 LOAD: writes one word per cycle, w[i] = latched key word i, for KEY_WORDS cycles, then moves to EXPAND.
REQ-018 EXPAND: writes one word per cycle, w[i] = w[i-KEY_WORDS] ^ t, where t is chosen as follows.
- i%KEY_WORDS==0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon advances by xtime (GF(2^8), poly 0x11B).
- KEY_WORDS==8 and i%8==4: t = SubWord(w[i-1]).
- Otherwise: t = w[i-1].
REQ-019 When i reaches TOTAL_WORDS-1, the FSM SHALL move to DONE; DONE lasts one cycle, pulses done, sets keys_ready, and moves to IDLE.
REQ-020 Total latency from the start cycle to the done pulse SHALL be TOTAL_WORDS+1 cycles (45, 53 or 61).
REQ-021 In the cycle after w[i] is written with i%4==3, rk_valid SHALL pulse with rk_index=i/4 and rk_data={w[i-3],w[i-2],w[i-1],w[i]}.
REQ-022 Exactly NUM_ROUNDS+1 rk_valid pulses SHALL occur per expansion, and round indices SHALL be strictly ascending.
REQ-023 busy SHALL be 1 in LOAD and EXPAND and 0 in IDLE and DONE.
REQ-024 start while busy SHALL be ignored, with no re-latch and no restart.
REQ-025 start in the DONE cycle SHALL be ignored; start is accepted only in IDLE.
REQ-026 Storage SHALL be TOTAL_WORDS x 32 bits.
REQ-027 An rd_round greater than NUM_ROUNDS SHALL return 0.
REQ-028 rd_data SHALL be defined only while keys_ready=1; it is don't-care otherwise.
REQ-029 rcon SHALL never be used more than 10 times for KEY_WORDS=4, 8 times for 6, and 7 times for 8.

Reset
REQ-030 rst=1 at any clock edge SHALL force IDLE and set busy=0, done=0, rk_valid=0, rk_index=0, rk_data=0, rd_data=0, keys_ready=0, i=0, rcon=0x01.
REQ-031 Reset during LOAD or EXPAND SHALL abort the expansion with no done pulse; storage contents need not be cleared.
REQ-032 rst and start asserted together SHALL resolve as reset; start is ignored.

Structure
REQ-033 A shared package SHALL hold the state enum type, the AES S-box constant table, and the xtime function.
REQ-034 Word substitution SHALL be one combinational sub-module, sub_word: four S-box lookups on a 32-bit word, instantiated once.
REQ-035 The word store SHALL be inferred as RAM within this module; no external SRAM model is used.

Verification
REQ-036 KEY_WORDS=4, key 2b7e151628aed2a6abf7158809cf4f3c: the rk_index=10 pulse SHALL carry d014f9a8c9ee2589e13f0cc8b6630ca6, done SHALL arrive 45 cycles after start, and there SHALL be 11 rk_valid pulses.
REQ-037 KEY_WORDS=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: round 12 SHALL be e98ba06f448c773c8ecc720401002202, with done at 53 cycles.
REQ-038 KEY_WORDS=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: round 14 SHALL be fe4890d1e6188d0b046df344706c631e, with done at 61 cycles.
REQ-039 A second start pulse 10 cycles into an expansion SHALL be ignored, and results SHALL be identical to REQ-036.
REQ-040 rst asserted 20 cycles into an expansion SHALL clear all outputs next cycle with no done pulse; a restart with the REQ-036 key SHALL give the same results.
REQ-041 After done, a sweep of rd_round 0..15 SHALL return the stored round keys with 1-cycle latency, and 0 for rd_round greater than NUM_ROUNDS.
